// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins ties, but fetch is guaranteed a grant after MAX_D_STREAK back-to-back data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 3,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t              state, stateNext;
  logic [STREAK_W-1:0] streak, streakNext;
  logic [7:0]          waitCnt, waitCntNext;
  logic                memReqNext, memWeNext, ifReadyNext, dReadyNext, errNext;
  logic [ADDR_W-1:0]   memAddrNext;
  logic [DATA_W-1:0]   memWdataNext, ifRdataNext, dRdataNext, doneData;
  logic                ifElig, dElig, grantD, txnDone;

  always_comb begin
    stateNext    = state;
    streakNext   = streak;
    waitCntNext  = waitCnt;
    memReqNext   = mem_req;
    memWeNext    = mem_we;
    memAddrNext  = mem_addr;
    memWdataNext = mem_wdata;
    ifReadyNext  = 1'b0;
    dReadyNext   = 1'b0;
    ifRdataNext  = if_rdata;
    dRdataNext   = d_rdata;
    errNext      = err;
    // A request still held during its own ready cycle must not be granted again.
    ifElig   = if_req & ~if_ready;
    dElig    = d_req & ~d_ready;
    grantD   = dElig & ~(ifElig & (streak >= STREAK_MAX));
    txnDone  = mem_ack | (waitCnt == TIMEOUT_LAST);
    doneData = mem_ack ? mem_rdata : '0;

    case (state)
      IDLE: begin
        if (grantD) begin
          stateNext    = BUSY_D;
          streakNext   = ifElig ? streak + STREAK_W'(1) : '0;
          memReqNext   = 1'b1;
          memWeNext    = d_we;
          memAddrNext  = d_addr;
          memWdataNext = d_wdata;
          waitCntNext  = '0;
        end else if (ifElig) begin
          stateNext    = BUSY_IF;
          streakNext   = '0;
          memReqNext   = 1'b1;
          memWeNext    = 1'b0;
          memAddrNext  = if_addr;
          memWdataNext = '0;
          waitCntNext  = '0;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (txnDone) begin
          stateNext  = IDLE;
          memReqNext = 1'b0;
          memWeNext  = 1'b0;
          if (!mem_ack) errNext = 1'b1;
          if (state == BUSY_D) begin
            dReadyNext = 1'b1;
            dRdataNext = doneData;
          end else begin
            ifReadyNext = 1'b1;
            ifRdataNext = doneData;
          end
        end else begin
          waitCntNext = waitCnt + 8'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      waitCnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= stateNext;
      streak    <= streakNext;
      waitCnt   <= waitCntNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      if_ready  <= ifReadyNext;
      d_ready   <= dReadyNext;
      if_rdata  <= ifRdataNext;
      d_rdata   <= dRdataNext;
      err       <= errNext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic, all checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MAXS = 3, TO = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic if_ready, d_ready, mem_req, mem_we, err;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, exp);
    end
  endtask

  // Reference model: who owns the memory, how long it has been waiting, and the visible outputs.
  int          mOwner = 0;   // 0 = nobody, 1 = fetch, 2 = data
  int          mStreak = 0;
  int          mBusyCycles = 0;
  logic        mReq = 0, mWe = 0, mIfReady = 0, mDReady = 0, mErr = 0;
  logic [31:0] mAddr = 0, mWdata = 0, mIfRdata = 0, mDRdata = 0;

  task automatic modelStep();
    logic eIf, eD;
    logic [31:0] data;
    if (reset) begin
      mOwner = 0; mStreak = 0; mBusyCycles = 0;
      mReq = 0; mWe = 0; mIfReady = 0; mDReady = 0; mErr = 0;
      mAddr = 0; mWdata = 0; mIfRdata = 0; mDRdata = 0;
      return;
    end
    eIf = if_req && !mIfReady;
    eD  = d_req && !mDReady;
    mIfReady = 0;
    mDReady  = 0;
    if (mOwner == 0) begin
      if (eD && !(eIf && mStreak >= MAXS)) begin
        mOwner = 2; mStreak = eIf ? mStreak + 1 : 0;
        mReq = 1; mWe = d_we; mAddr = d_addr; mWdata = d_wdata; mBusyCycles = 0;
      end else if (eIf) begin
        mOwner = 1; mStreak = 0;
        mReq = 1; mWe = 0; mAddr = if_addr; mWdata = 0; mBusyCycles = 0;
      end
    end else begin
      mBusyCycles++;
      if (mem_ack || mBusyCycles == TO) begin
        data = mem_ack ? mem_rdata : 32'h0;
        if (!mem_ack) mErr = 1;
        if (mOwner == 1) begin mIfReady = 1; mIfRdata = data; end
        else begin mDReady = 1; mDRdata = data; end
        mOwner = 0; mReq = 0; mWe = 0;
      end
    end
  endtask

  // Memory responder state
  int          ackWait = 0;
  int          busyCyc = 0;
  logic [31:0] ackData = 0;
  bit          rndMode = 0;

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    cycle++;
    chk("model_ctrl", {59'd0, mem_req, mem_we, if_ready, d_ready, err},
        {59'd0, mReq, mWe, mIfReady, mDReady, mErr});
    chk("model_addr", mem_addr, mAddr);
    chk("model_wdata", mem_wdata, mWdata);
    chk("model_if_rdata", if_rdata, mIfRdata);
    chk("model_d_rdata", d_rdata, mDRdata);
    if (mem_req) begin
      if (busyCyc == 0 && rndMode) ackWait = $urandom_range(0, 4);
      mem_ack = (ackWait >= 0 && busyCyc == ackWait);
      busyCyc++;
    end else begin
      busyCyc = 0;
      mem_ack = rndMode ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
    mem_rdata = rndMode ? DW'($urandom) : ackData;
  endtask

  typedef struct {
    bit          isD;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waitC;
    logic [31:0] ackD;
    logic        expWe;
    logic [31:0] expMemWdata;
    logic [31:0] expRdata;
  } vec_t;

  task automatic runRow(input vec_t v, input string tag);
    int lat, busyN;
    logic rdy;
    ackWait = v.waitC;
    ackData = v.ackD;
    if (v.isD) begin d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; end
    else begin if_req = 1; if_addr = v.addr; end
    tick();
    chk({tag, "_grant_req"}, mem_req, 1'b1);
    chk({tag, "_grant_addr"}, mem_addr, v.addr);
    chk({tag, "_grant_we"}, mem_we, v.expWe);
    chk({tag, "_grant_wdata"}, mem_wdata, v.expMemWdata);
    lat = 1; busyN = 1; rdy = 0;
    while (!rdy && lat < 300) begin
      tick();
      lat++;
      rdy = v.isD ? d_ready : if_ready;
      if (mem_req) begin
        busyN++;
        chk({tag, "_hold"}, {mem_we, mem_addr, mem_wdata}, {v.expWe, v.addr, v.expMemWdata});
      end
    end
    chk({tag, "_latency"}, lat, v.waitC + 2);
    chk({tag, "_busy_cycles"}, busyN, v.waitC + 1);
    chk({tag, "_rdata"}, v.isD ? d_rdata : if_rdata, v.expRdata);
    tick();  // request still held through the ready cycle
    chk({tag, "_no_regrant"}, {mem_req, if_ready, d_ready}, 3'b000);
    if_req = 0; d_req = 0; d_we = 0;
    tick();
  endtask

  vec_t vecs[4];
  int   grants[$];
  int   expGrants[8];
  int   n;
  logic prevReq;

  initial begin
    vecs[0] = '{0, 0, 32'h10, 32'h0, 0, 32'h00500093, 0, 32'h0, 32'h00500093};
    vecs[1] = '{1, 1, 32'h100, 32'hCAFEBABE, 3, 32'h11111111, 1, 32'hCAFEBABE, 32'h11111111};
    vecs[2] = '{1, 0, 32'h300, 32'h55555555, 1, 32'h12345678, 0, 32'h55555555, 32'h12345678};
    vecs[3] = '{0, 0, 32'h44, 32'h0, 2, 32'hABCD0001, 0, 32'h0, 32'hABCD0001};
    expGrants = '{2, 2, 2, 1, 2, 2, 2, 2};

    // Reset state
    reset = 1;
    tick(); tick();
    chk("reset_ctrl", {mem_req, mem_we, if_ready, d_ready, err}, 5'b0);
    chk("reset_data", {mem_addr, mem_wdata, if_rdata, d_rdata}, 128'h0);
    reset = 0;
    tick();

    for (int i = 0; i < 4; i++) runRow(vecs[i], $sformatf("vec%0d", i));

    // Fetch held continuously except while it sees d_ready: exercises the data streak limit.
    d_req = 1; if_req = 1; d_we = 0; d_addr = 32'h400; if_addr = 32'h800; ackWait = 0;
    prevReq = mem_req;
    n = 0;
    while (grants.size() < 8 && n < 200) begin
      tick();
      n++;
      if (mem_req && !prevReq) grants.push_back(mem_addr == 32'h400 ? 2 : 1);
      prevReq = mem_req;
      if_req = !d_ready;
    end
    chk("streak_count", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++) chk($sformatf("streak_grant%0d", i), grants[i], expGrants[i]);
    d_req = 0; if_req = 0;
    tick(); tick();

    // Simultaneous requests from a fresh reset: data first, fetch in the next IDLE cycle.
    reset = 1; tick(); reset = 0; tick();
    if_req = 1; if_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h600; ackWait = 0; ackData = 32'h77;
    tick();
    chk("simul_first_addr", mem_addr, 32'h600);
    tick();
    chk("simul_d_ready", d_ready, 1'b1);
    d_req = 0;
    tick();
    chk("simul_if_grant", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h500});
    tick();
    chk("simul_if_ready", {if_ready, if_rdata}, {1'b1, 32'h77});
    if_req = 0;
    tick();

    // Timeout: a load that never gets an acknowledge.
    ackWait = -1;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    tick();
    n = 1;
    while (!d_ready && n < 400) begin
      tick();
      if (mem_req) n++;
    end
    chk("timeout_busy_cycles", n, TO);
    chk("timeout_abort", {mem_req, d_ready, err, d_rdata}, {1'b0, 1'b1, 1'b1, 32'h0});
    d_req = 0;
    tick();
    runRow('{0, 0, 32'h20, 32'h0, 0, 32'h13, 0, 32'h0, 32'h13}, "after_timeout");
    chk("err_sticky", err, 1'b1);
    runRow('{1, 0, 32'h240, 32'h0, 0, 32'h1234, 0, 32'h0, 32'h1234}, "pre_reset_load");

    // Reset arrives in the same cycle as the acknowledge of a data transaction.
    d_req = 1; d_we = 0; d_addr = 32'h700; ackWait = 0; ackData = 32'hDEAD;
    tick();
    chk("midreset_busy", {mem_req, mem_ack}, 2'b11);
    reset = 1;
    tick();
    chk("midreset_state", {mem_req, d_ready, err, d_rdata, mem_addr}, 67'h0);
    reset = 0; d_req = 0;
    tick();

    // Randomized traffic checked against the model.
    rndMode = 1;
    for (int i = 0; i < 3000; i++) begin
      if_req  = ($urandom_range(0, 2) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1);
      if_addr = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      tick();
    end
    rndMode = 0;
    if_req = 0; d_req = 0; mem_ack = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cycle);
    $fatal(1, "watchdog expired");
  end
endmodule
